top_seven_seg_driver: RTL and testbench
=======================================

Name: top_seven_seg_driver

Overview:
- Time-multiplexed driver for a 4-digit, 7-segment display with decimal points.
- Takes four 4-bit hex nibbles plus four decimal-point flags.
- Cycles a one-hot digit enable using a free-running prescaler and drives the matching decoded segment pattern.
- Sits between the numeric datapath (counters, adders) and the board display pins.

Parameters:
- PRESCALER_BITS, 16: width of the scan counter; must be >= 2. Each digit is lit for 2^(PRESCALER_BITS-2) clocks; a full 4-digit scan takes 2^PRESCALER_BITS clocks.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hex_0_in  in  4  nibble for digit 0 (rightmost).
- hex_1_in  in  4  nibble for digit 1.
- hex_2_in  in  4  nibble for digit 2.
- hex_3_in  in  4  nibble for digit 3 (leftmost).
- dp_in  in  4  decimal-point flags; bit i belongs to digit i; 1 = point lit.
- en_disp  out  4  one-hot digit enable, active-high; bit i lights digit i.
- digit_out  out  8  segments, active-high: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g, bit7=dp.

Behaviour:
- Scan counter: PRESCALER_BITS-bit up-counter, increments every clk and wraps from all-ones to 0.
- Digit index: idx = counter[PRESCALER_BITS-1 : PRESCALER_BITS-2].
- Outputs are registered. On each rising edge:
  - en_disp <= 1 << idx (computed from the counter value before the increment).
  - digit_out <= {dp_in[idx], seg(hex_idx_in)}.
- Latency: one clock from counter value to outputs. Inputs are sampled live, with no input registers. An input change is visible at most one clock after its digit's slot begins, or at the next scan.
- seg() encoding (g..a, hex):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Reset (rst=0, asynchronous): counter=0, en_disp=4'b0000 (all digits dark), digit_out=8'h00. Reset asserted mid-scan blanks the outputs immediately.
- After reset release:
  - First rising edge: en_disp=0001, showing digit 0.
  - Digit i first appears on edge number i*2^(PRESCALER_BITS-2)+1.
  - Order is always 0,1,2,3,0,… with no gaps; exactly one en_disp bit is high at all times outside reset.
- Wrap: counter overflow returns to digit 0 seamlessly, with no idle cycle.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: digit 3 is blanked when hex_3_in==0. Digit 2 is blanked when hex_3_in and hex_2_in are both 0. Digit 1 is blanked when hex_3..1 are all 0. Digit 0 is never blanked.
- Blanked means segment bits [6:0]=0. The dp bit still follows dp_in, and en_disp still scans normally.
- Undefined: all four digits are always decoded.

Decomposition:
- Shared package holds:
  - the 16-entry segment constant table (SEG_0..SEG_F);
  - DIGITS=4;
  - segment bit-position constants (SEG_A..SEG_G, SEG_DP).
- One natural sub-module: hex7seg_decoder (4-bit nibble -> 7-bit g..a pattern, purely combinational), instantiated once after the digit mux.

Test Plan:
- Reset: hold rst=0 and toggle clk -> en_disp=0000 and digit_out=00. Assert rst=0 mid-scan -> both outputs clear immediately, without waiting for a clock edge.
- Scan with PRESCALER_BITS=6, hex_0..3=1,5,A,F, dp_in=4'hA:
  - digit 0 (en_disp=0001) -> digit_out=06
  - digit 1 (en_disp=0010) -> digit_out=ED
  - digit 2 (en_disp=0100) -> digit_out=77
  - digit 3 (en_disp=1000) -> digit_out=F1
  - each digit held 16 clocks; pattern repeats every 64 clocks.
- Decoder sweep: hold all nibbles at v for v=0..F with dp_in=0 -> every slot shows the table value for v.
- Wrap/timing: count edges after reset release -> en_disp changes exactly on edges 17, 33, 49 and 65, returning to 0001 on edge 65. en_disp is always one-hot.
- Live input change: change hex_2_in during digit 2's slot -> new pattern appears on the next edge.
- With LEADING_ZERO_BLANK_EN, hex=0,0,0,7 (hex_0..3 = 0,0,0,7) and dp_in=0:
  - digit 0 -> 3F (never blanked)
  - digit 1 -> 3F (digit 3 is non-zero)
  - digit 2 -> 3F
  - digit 3 -> 07
- With LEADING_ZERO_BLANK_EN, hex=5,0,0,0 (hex_0..3 = 5,0,0,0) and dp_in=0:
  - digit 0 -> 6D
  - digits 1..3 -> 00

Source files
------------

// File: rtl/top_seven_seg_driver_pkg.sv
// Shared constants for the 4-digit seven-segment driver: segment table,
// digit count and segment bit positions.
package top_seven_seg_driver_pkg;

    localparam int DIGITS = 4;

    // Segment bit positions within digit_out (active-high).
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    // g..a patterns for hex digits 0-F.
    localparam seg_t SEG_0 = 7'h3F;
    localparam seg_t SEG_1 = 7'h06;
    localparam seg_t SEG_2 = 7'h5B;
    localparam seg_t SEG_3 = 7'h4F;
    localparam seg_t SEG_4 = 7'h66;
    localparam seg_t SEG_5 = 7'h6D;
    localparam seg_t SEG_6 = 7'h7D;
    localparam seg_t SEG_7 = 7'h07;
    localparam seg_t SEG_8 = 7'h7F;
    localparam seg_t SEG_9 = 7'h6F;
    localparam seg_t SEG_A_HEX = 7'h77;
    localparam seg_t SEG_B_HEX = 7'h7C;
    localparam seg_t SEG_C_HEX = 7'h39;
    localparam seg_t SEG_D_HEX = 7'h5E;
    localparam seg_t SEG_E_HEX = 7'h79;
    localparam seg_t SEG_F_HEX = 7'h71;

    function automatic logic [DIGITS-1:0] digit_onehot(input digit_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/top_seven_seg_driver_if.sv
// Display-side bundle: nibbles and dp flags in, digit enables and segments out,
// plus the live scan index for observation.
interface top_seven_seg_driver_if;
    import top_seven_seg_driver_pkg::*;

    nibble_t               hex_0_in;
    nibble_t               hex_1_in;
    nibble_t               hex_2_in;
    nibble_t               hex_3_in;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     en_disp;
    logic [7:0]            digit_out;
    digit_idx_t            dbg_scan_idx;

    // No handshake: nibbles and dp flags are sampled live every clock, and the
    // outputs are free-running registered values with no valid/ready qualifier.
    modport master (
        output hex_0_in, hex_1_in, hex_2_in, hex_3_in, dp_in,
        input  en_disp, digit_out, dbg_scan_idx
    );

    modport slave (
        input  hex_0_in, hex_1_in, hex_2_in, hex_3_in, dp_in,
        output en_disp, digit_out, dbg_scan_idx
    );

endinterface

// File: rtl/top_seven_seg_driver_hex7seg_decoder.sv
// Purely combinational 4-bit hex nibble to g..a seven-segment pattern decoder.
module hex7seg_decoder
    import top_seven_seg_driver_pkg::*;
(
    input  nibble_t hex_i,
    output seg_t    seg_o
);

    always_comb begin
        seg_o = SEG_0;
        case (hex_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A_HEX;
            4'hB:    seg_o = SEG_B_HEX;
            4'hC:    seg_o = SEG_C_HEX;
            4'hD:    seg_o = SEG_D_HEX;
            4'hE:    seg_o = SEG_E_HEX;
            4'hF:    seg_o = SEG_F_HEX;
            default: seg_o = SEG_0;
        endcase
    end

endmodule

// File: rtl/top_seven_seg_driver.sv
// Time-multiplexed 4-digit seven-segment driver with registered outputs.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module top_seven_seg_driver
    import top_seven_seg_driver_pkg::*;
#(
    parameter int PRESCALER_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    top_seven_seg_driver_if.slave   disp
);

    logic [PRESCALER_BITS-1:0] counter_q, counter_d;
    logic [DIGITS-1:0]         en_disp_q, en_disp_d;
    logic [7:0]                digit_out_q, digit_out_d;

    digit_idx_t        idx;
    nibble_t           hex_sel;
    logic              dp_sel;
    seg_t              seg_raw;
    seg_t              seg_shown;
    logic [DIGITS-1:0] blank;

    // The top two counter bits select the digit, so each slot is a quarter scan.
    assign idx = counter_q[PRESCALER_BITS-1 -: 2];

    always_comb begin
        hex_sel = disp.hex_0_in;
        case (idx)
            2'd0:    hex_sel = disp.hex_0_in;
            2'd1:    hex_sel = disp.hex_1_in;
            2'd2:    hex_sel = disp.hex_2_in;
            2'd3:    hex_sel = disp.hex_3_in;
            default: hex_sel = disp.hex_0_in;
        endcase
    end

    assign dp_sel = disp.dp_in[idx];

    hex7seg_decoder u_decoder (
        .hex_i (hex_sel),
        .seg_o (seg_raw)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank only if it and every digit to its left are zero;
    // digit 0 always shows so a zero value still displays "0".
    always_comb begin
        blank    = '0;
        blank[3] = (disp.hex_3_in == 4'h0);
        blank[2] = blank[3] && (disp.hex_2_in == 4'h0);
        blank[1] = blank[2] && (disp.hex_1_in == 4'h0);
    end
`else
    assign blank = '0;
`endif

    assign seg_shown = blank[idx] ? '0 : seg_raw;

    always_comb begin
        counter_d   = counter_q + {{(PRESCALER_BITS-1){1'b0}}, 1'b1};
        en_disp_d   = digit_onehot(idx);
        digit_out_d = {dp_sel, seg_shown};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter_q   <= '0;
            en_disp_q   <= '0;
            digit_out_q <= '0;
        end else begin
            counter_q   <= counter_d;
            en_disp_q   <= en_disp_d;
            digit_out_q <= digit_out_d;
        end
    end

    assign disp.en_disp      = en_disp_q;
    assign disp.digit_out    = digit_out_q;
    assign disp.dbg_scan_idx = idx;

endmodule

// File: tb/tb_top_seven_seg_driver.sv
// Self-checking bench for top_seven_seg_driver with a 6-bit prescaler.
module tb_top_seven_seg_driver;
    import top_seven_seg_driver_pkg::*;

    localparam int PB   = 6;
    localparam int SLOT = 1 << (PB - 2);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    top_seven_seg_driver_if disp_if ();

    top_seven_seg_driver #(.PRESCALER_BITS(PB)) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (disp_if)
    );

    // ---------------- reference model ----------------
    logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          edge_n;
    logic [15:0] cur_hex;
    logic [3:0]  cur_dp;
    logic [11:0] exp_q[$];
    int          n_checks;
    int          n_errors;

    // Edge e after reset release shows digit ((e-1)/SLOT) mod 4.
    function automatic int digit_at(input int e);
        return ((e - 1) / SLOT) % 4;
    endfunction

    function automatic logic [11:0] model_out(input int e, input logic [15:0] hx, input logic [3:0] dp);
        int         d;
        logic [3:0] nib;
        logic [6:0] s;
        logic [3:0] en;
        d   = digit_at(e);
        nib = hx[d*4 +: 4];
        s   = seg_ref[nib];
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (hx >> (d*4)) == 16'h0) s = 7'h00;
`endif
        en = 4'b0001 << d;
        return {en, dp[d], s};
    endfunction

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_inputs(input logic [15:0] hx, input logic [3:0] dp);
        cur_hex           = hx;
        cur_dp            = dp;
        disp_if.hex_0_in  = hx[3:0];
        disp_if.hex_1_in  = hx[7:4];
        disp_if.hex_2_in  = hx[11:8];
        disp_if.hex_3_in  = hx[15:12];
        disp_if.dp_in     = dp;
    endtask

    // One rising edge, then compare against the model 1 time unit later.
    task automatic step();
        logic [11:0] exp;
        @(posedge clk);
        edge_n++;
        exp_q.push_back(model_out(edge_n, cur_hex, cur_dp));
        #1;
        exp = exp_q.pop_front();
        check_val("scan", {disp_if.en_disp, disp_if.digit_out}, exp);
        check_val("onehot", 12'($onehot(disp_if.en_disp)), 12'd1);
    endtask

    task automatic hold_reset(input int cycles);
        rst = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check_val("rst_hold", {disp_if.en_disp, disp_if.digit_out}, 12'h000);
        end
        @(negedge clk);
        rst    = 1'b1;
        edge_n = 0;
    endtask

    // Runs n edges, checking each slot against a fixed per-digit expectation.
    task automatic run_pattern(input string tag, input int n, input logic [31:0] exp_digits);
        int d;
        for (int i = 0; i < n; i++) begin
            step();
            d = digit_at(edge_n);
            check_val(tag, {4'h0, disp_if.digit_out}, {4'h0, exp_digits[d*8 +: 8]});
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  prev_en;
        logic [15:0] rh;
        logic [3:0]  v;
        int          waited;

        n_checks = 0;
        n_errors = 0;
        edge_n   = 0;
        set_inputs(16'hFA51, 4'hA);

        // Reset hold, then release.
        hold_reset(4);

        // Fixed pattern 1,5,A,F with dp=A; also check slot edges.
        prev_en = 4'b0000;
        for (int i = 0; i < 2 * 64; i++) begin
            step();
            case (digit_at(edge_n))
                0: check_val("pat_d0", {4'h0, disp_if.digit_out}, 12'h006);
                1: check_val("pat_d1", {4'h0, disp_if.digit_out}, 12'h0ED);
                2: check_val("pat_d2", {4'h0, disp_if.digit_out}, 12'h077);
                default: check_val("pat_d3", {4'h0, disp_if.digit_out}, 12'h0F1);
            endcase
            if (edge_n == 1)  check_val("edge1_en",  {8'h0, disp_if.en_disp}, 12'h001);
            if (edge_n == 17) check_val("edge17_en", {8'h0, disp_if.en_disp}, 12'h002);
            if (edge_n == 33) check_val("edge33_en", {8'h0, disp_if.en_disp}, 12'h004);
            if (edge_n == 49) check_val("edge49_en", {8'h0, disp_if.en_disp}, 12'h008);
            if (edge_n == 65) check_val("edge65_en", {8'h0, disp_if.en_disp}, 12'h001);
            if (edge_n > 1)
                check_val("en_change", 12'(disp_if.en_disp != prev_en),
                          12'((edge_n % SLOT) == 1));
            prev_en = disp_if.en_disp;
        end

        // Live change of hex_2 during digit 2's slot.
        waited = 0;
        while (disp_if.en_disp != 4'b0100 && waited < 64) begin
            step();
            waited++;
        end
        check_val("reach_d2", {8'h0, disp_if.en_disp}, 12'h004);
        step();
        step();
        set_inputs({cur_hex[15:12], 4'h3, cur_hex[7:0]}, cur_dp);
        step();
        check_val("live_chg", {4'h0, disp_if.digit_out}, 12'h04F);

        // Decoder sweep: all nibbles equal, dp off.
        for (int k = 0; k < 16; k++) begin
            v = 4'(k);
            set_inputs({v, v, v, v}, 4'h0);
            for (int i = 0; i < 64; i++) step();
        end

`ifdef LEADING_ZERO_BLANK_EN
        set_inputs(16'h7000, 4'h0);
        run_pattern("lzb_7000", 64, 32'h07_3F_3F_3F);
        set_inputs(16'h0005, 4'h0);
        run_pattern("lzb_0005", 64, 32'h00_00_00_6D);
        set_inputs(16'h0005, 4'hF);
        run_pattern("lzb_dp", 64, 32'h80_80_80_ED);
`else
        set_inputs(16'h7000, 4'h0);
        run_pattern("full_7000", 64, 32'h07_3F_3F_3F);
        set_inputs(16'h0005, 4'h0);
        run_pattern("full_0005", 64, 32'h3F_3F_3F_6D);
`endif

        // Randomized inputs, biased toward zero nibbles.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int j = 0; j < 4; j++)
                    rh[j*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                set_inputs(rh, 4'($urandom_range(0, 15)));
            end
            step();
        end

        // Asynchronous reset mid-scan: outputs clear without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        check_val("async_rst", {disp_if.en_disp, disp_if.digit_out}, 12'h000);
        hold_reset(2);
        set_inputs(16'hFA51, 4'hA);
        run_pattern("post_rst", 64, 32'hF1_77_ED_06);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
